// File: rtl/multi_channel_watchdog.sv
// multi_channel_watchdog: N independent heartbeat supervisors with a shared,
// lowest-index fault report and a fixed-length system reset pulse.
//
// Channel FSM states:
//   state   | meaning
//   IDLE    | channel disabled, counter held at 0, no flags
//   RUN     | counting cycles since the last heartbeat, warning decoded here
//   TRIP    | heartbeat missed for TIMEOUT_CYCLES, counter saturated
module multi_channel_watchdog #(
  parameter int N_CH           = 4,
  parameter int WARN_CYCLES    = 6,
  parameter int TIMEOUT_CYCLES = 10,
  parameter int RESET_PULSE    = 3,
  parameter int STICKY         = 1,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         heartbeat,
  input  logic [N_CH-1:0]         enable,
  input  logic [N_CH-1:0]         clear,
  input  logic                    force_reset,
  output logic [N_CH-1:0]         warning,
  output logic [N_CH-1:0]         triggered,
  output logic                    any_trip,
  output logic [3:0]              fault_id,
  output logic                    sys_reset_o,
  output logic [N_CH*CNT_W-1:0]   count_o
);

  localparam int PW = $clog2(RESET_PULSE + 1);
  localparam logic [CNT_W-1:0] LP_TIMEOUT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LP_LAST_RUN = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_WARN     = CNT_W'(WARN_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRIP = 2'd2
  } state_t;

  state_t           r_state     [N_CH];
  state_t           w_state_nxt [N_CH];
  logic [CNT_W-1:0] r_cnt       [N_CH];
  logic [CNT_W-1:0] w_cnt_nxt   [N_CH];

  logic [N_CH-1:0]  r_trig_prev;
  logic [PW-1:0]    r_pulse_cnt;
  logic             w_event;

  // Channel state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Next-state logic; disable beats clear, clear beats heartbeat, heartbeat beats counting.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (!enable[i]) begin
        w_state_nxt[i] = ST_IDLE;
        w_cnt_nxt[i]   = '0;
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            w_state_nxt[i] = ST_RUN;
            w_cnt_nxt[i]   = '0;
          end
          ST_RUN: begin
            if (heartbeat[i]) begin
              w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == LP_LAST_RUN) begin
              w_state_nxt[i] = ST_TRIP;
              w_cnt_nxt[i]   = LP_TIMEOUT;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
          end
          ST_TRIP: begin
            // Non-sticky builds let a late heartbeat recover the channel.
            if (clear[i] || (STICKY == 0 && heartbeat[i])) begin
              w_state_nxt[i] = ST_RUN;
              w_cnt_nxt[i]   = '0;
            end else begin
              w_cnt_nxt[i] = LP_TIMEOUT;
            end
          end
          default: begin
            w_state_nxt[i] = ST_IDLE;
            w_cnt_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  // Per-channel flag decode from registered state, plus packed counter view.
  always_comb begin
    warning   = '0;
    triggered = '0;
    count_o   = '0;
    for (int i = 0; i < N_CH; i++) begin
      triggered[i] = (r_state[i] == ST_TRIP);
      warning[i]   = (r_state[i] == ST_RUN) && (r_cnt[i] >= LP_WARN);
      count_o[i*CNT_W +: CNT_W] = r_cnt[i];
    end
  end

  // Lowest-index fault report; scanning downward lets the lowest index win.
  always_comb begin
    fault_id = 4'd0;
    any_trip = |triggered;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (triggered[i]) fault_id = 4'(i);
    end
  end

  assign w_event     = (|(triggered & ~r_trig_prev)) | force_reset;
  assign sys_reset_o = (r_pulse_cnt != '0);

  // Pulse generator: one fixed-length pulse per event, events during a pulse dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trig_prev <= '0;
      r_pulse_cnt <= '0;
    end else begin
      r_trig_prev <= triggered;
      if (r_pulse_cnt != '0) begin
        r_pulse_cnt <= r_pulse_cnt - PW'(1);
      end else if (w_event) begin
        r_pulse_cnt <= PW'(RESET_PULSE);
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Directed bench for multi_channel_watchdog: a sticky instance (main DUT) and a
// non-sticky instance sharing the same stimulus.
module tb_multi_channel_watchdog;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  heartbeat, enable, clear;
  logic        force_reset;

  logic [3:0]  warning, triggered, fault_id;
  logic        any_trip, sys_reset_o;
  logic [15:0] count_o;

  logic [3:0]  warning_ns, triggered_ns, fault_id_ns;
  logic        any_trip_ns, sys_reset_ns;
  logic [15:0] count_ns;

  int errors = 0;
  int checks = 0;

  multi_channel_watchdog #(.N_CH(4), .WARN_CYCLES(6), .TIMEOUT_CYCLES(10),
                           .RESET_PULSE(3), .STICKY(1)) dut (
    .clk(clk), .rst(rst), .heartbeat(heartbeat), .enable(enable), .clear(clear),
    .force_reset(force_reset), .warning(warning), .triggered(triggered),
    .any_trip(any_trip), .fault_id(fault_id), .sys_reset_o(sys_reset_o),
    .count_o(count_o));

  multi_channel_watchdog #(.N_CH(4), .WARN_CYCLES(6), .TIMEOUT_CYCLES(10),
                           .RESET_PULSE(3), .STICKY(0)) dut_ns (
    .clk(clk), .rst(rst), .heartbeat(heartbeat), .enable(enable), .clear(clear),
    .force_reset(force_reset), .warning(warning_ns), .triggered(triggered_ns),
    .any_trip(any_trip_ns), .fault_id(fault_id_ns), .sys_reset_o(sys_reset_ns),
    .count_o(count_ns));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] cnt_of(input logic [15:0] v, input int ch);
    return v[ch*4 +: 4];
  endfunction

  task automatic do_reset;
    rst = 1'b1; enable = '0; heartbeat = '0; clear = '0; force_reset = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 4'hF; heartbeat = 4'hF; clear = '0; force_reset = 1'b1;
    tick;
    rst = 1'b0; enable = '0; heartbeat = '0; force_reset = 1'b0;
    checks++; if (triggered !== 4'b0) begin errors++; $display("FAIL reset_triggered got %b exp 0000", triggered); end
    checks++; if (warning !== 4'b0) begin errors++; $display("FAIL reset_warning got %b exp 0000", warning); end
    checks++; if (any_trip !== 1'b0) begin errors++; $display("FAIL reset_any_trip got %b exp 0", any_trip); end
    checks++; if (fault_id !== 4'd0) begin errors++; $display("FAIL reset_fault_id got %0d exp 0", fault_id); end
    checks++; if (sys_reset_o !== 1'b0) begin errors++; $display("FAIL reset_sys_reset got %b exp 0", sys_reset_o); end
    checks++; if (count_o !== 16'h0) begin errors++; $display("FAIL reset_count got %h exp 0000", count_o); end
  endtask

  task automatic test_basic_timeout;
    logic [3:0] exp_cnt;
    do_reset;
    enable = 4'b0001;
    tick;
    heartbeat = 4'b0001;
    tick;
    heartbeat = '0;
    for (int k = 1; k <= 14; k++) begin
      tick;
      exp_cnt = (k < 10) ? 4'(k) : 4'd10;
      checks++; if (cnt_of(count_o, 0) !== exp_cnt) begin errors++; $display("FAIL timeout_count edge %0d got %0d exp %0d", k, cnt_of(count_o, 0), exp_cnt); end
      checks++; if (warning[0] !== (k >= 6 && k < 10)) begin errors++; $display("FAIL timeout_warning edge %0d got %b", k, warning[0]); end
      checks++; if (triggered[0] !== (k >= 10)) begin errors++; $display("FAIL timeout_triggered edge %0d got %b", k, triggered[0]); end
      checks++; if (sys_reset_o !== (k >= 11 && k <= 13)) begin errors++; $display("FAIL timeout_sys_reset edge %0d got %b", k, sys_reset_o); end
    end
  endtask

  task automatic test_keepalive;
    do_reset;
    enable = 4'b0001;
    tick;
    for (int c = 0; c < 100; c++) begin
      heartbeat = (c % 9 == 0) ? 4'b0001 : 4'b0000;
      tick;
      checks++; if (cnt_of(count_o, 0) !== 4'(c % 9)) begin errors++; $display("FAIL keepalive_count cycle %0d got %0d exp %0d", c, cnt_of(count_o, 0), c % 9); end
      checks++; if (warning[0] !== (c % 9 >= 6)) begin errors++; $display("FAIL keepalive_warning cycle %0d got %b", c, warning[0]); end
      checks++; if (triggered[0] !== 1'b0 || sys_reset_o !== 1'b0) begin errors++; $display("FAIL keepalive_trip cycle %0d got trig %b rst %b exp 0 0", c, triggered[0], sys_reset_o); end
    end
    heartbeat = '0;
  endtask

  task automatic test_boundary_race;
    do_reset;
    enable = 4'b0001;
    tick;
    heartbeat = 4'b0001;
    tick;
    heartbeat = '0;
    repeat (9) tick;
    checks++; if (cnt_of(count_o, 0) !== 4'd9) begin errors++; $display("FAIL race_pre_count got %0d exp 9", cnt_of(count_o, 0)); end
    heartbeat = 4'b0001;
    tick;
    heartbeat = '0;
    checks++; if (cnt_of(count_o, 0) !== 4'd0) begin errors++; $display("FAIL race_count got %0d exp 0", cnt_of(count_o, 0)); end
    checks++; if (triggered[0] !== 1'b0) begin errors++; $display("FAIL race_triggered got %b exp 0", triggered[0]); end
    tick;
    checks++; if (sys_reset_o !== 1'b0 || triggered[0] !== 1'b0) begin errors++; $display("FAIL race_no_pulse got rst %b trig %b exp 0 0", sys_reset_o, triggered[0]); end
    checks++; if (cnt_of(count_o, 0) !== 4'd1) begin errors++; $display("FAIL race_post_count got %0d exp 1", cnt_of(count_o, 0)); end
  endtask

  task automatic test_multi_sticky;
    logic [3:0] exp_trig, exp_fid;
    do_reset;
    enable = 4'b0110;
    tick;
    heartbeat = 4'b0110; tick;
    heartbeat = 4'b0000; tick;
    heartbeat = 4'b0010; tick;
    heartbeat = 4'b0000;
    for (int k = 3; k <= 16; k++) begin
      tick;
      exp_trig = {1'b0, k >= 10, k >= 12, 1'b0};
      exp_fid  = (k >= 12) ? 4'd1 : (k >= 10) ? 4'd2 : 4'd0;
      checks++; if (triggered !== exp_trig) begin errors++; $display("FAIL multi_triggered edge %0d got %b exp %b", k, triggered, exp_trig); end
      checks++; if (fault_id !== exp_fid) begin errors++; $display("FAIL multi_fault_id edge %0d got %0d exp %0d", k, fault_id, exp_fid); end
      checks++; if (any_trip !== (k >= 10)) begin errors++; $display("FAIL multi_any_trip edge %0d got %b", k, any_trip); end
      checks++; if (sys_reset_o !== (k >= 11 && k <= 13)) begin errors++; $display("FAIL multi_sys_reset edge %0d got %b", k, sys_reset_o); end
      checks++; if (cnt_of(count_o, 2) !== ((k < 10) ? 4'(k) : 4'd10)) begin errors++; $display("FAIL multi_count2 edge %0d got %0d", k, cnt_of(count_o, 2)); end
    end
    heartbeat = 4'b0010;
    tick;
    heartbeat = '0;
    checks++; if (triggered !== 4'b0110 || fault_id !== 4'd1) begin errors++; $display("FAIL sticky_hb_ignored got trig %b fid %0d exp 0110 1", triggered, fault_id); end
    checks++; if (triggered_ns !== 4'b0100) begin errors++; $display("FAIL nonsticky_hb1 got %b exp 0100", triggered_ns); end
    clear = 4'b0010;
    tick;
    clear = '0;
    checks++; if (triggered !== 4'b0100 || fault_id !== 4'd2) begin errors++; $display("FAIL sticky_clear got trig %b fid %0d exp 0100 2", triggered, fault_id); end
    checks++; if (cnt_of(count_o, 1) !== 4'd0) begin errors++; $display("FAIL sticky_clear_count got %0d exp 0", cnt_of(count_o, 1)); end
    heartbeat = 4'b0100;
    tick;
    heartbeat = '0;
    checks++; if (triggered[2] !== 1'b1 || cnt_of(count_o, 2) !== 4'd10) begin errors++; $display("FAIL sticky_hb2 got trig %b cnt %0d exp 1 10", triggered[2], cnt_of(count_o, 2)); end
    checks++; if (triggered_ns !== 4'b0000 || cnt_of(count_ns, 2) !== 4'd0) begin errors++; $display("FAIL nonsticky_hb2 got trig %b cnt %0d exp 0000 0", triggered_ns, cnt_of(count_ns, 2)); end
    checks++; if (sys_reset_o !== 1'b0) begin errors++; $display("FAIL multi_no_second_pulse got %b exp 0", sys_reset_o); end
  endtask

  task automatic test_force_disable;
    logic [3:0] exp_cnt;
    do_reset;
    enable = 4'b0001;
    tick;
    heartbeat = 4'b0001; tick;
    heartbeat = '0;
    repeat (3) tick;
    force_reset = 1'b1;
    tick;
    force_reset = 1'b0;
    checks++; if (sys_reset_o !== 1'b1 || cnt_of(count_o, 0) !== 4'd4) begin errors++; $display("FAIL force_start got rst %b cnt %0d exp 1 4", sys_reset_o, cnt_of(count_o, 0)); end
    checks++; if (triggered !== 4'b0) begin errors++; $display("FAIL force_no_trip got %b exp 0000", triggered); end
    for (int k = 5; k <= 12; k++) begin
      tick;
      exp_cnt = (k < 10) ? 4'(k) : 4'd10;
      checks++; if (cnt_of(count_o, 0) !== exp_cnt) begin errors++; $display("FAIL force_count edge %0d got %0d exp %0d", k, cnt_of(count_o, 0), exp_cnt); end
      checks++; if (sys_reset_o !== (k <= 6 || (k >= 11 && k <= 13))) begin errors++; $display("FAIL force_sys_reset edge %0d got %b", k, sys_reset_o); end
      checks++; if (triggered[0] !== (k >= 10)) begin errors++; $display("FAIL force_triggered edge %0d got %b", k, triggered[0]); end
    end
    enable = 4'b0000;
    tick;
    checks++; if (triggered[0] !== 1'b0 || any_trip !== 1'b0) begin errors++; $display("FAIL disable_trip got trig %b any %b exp 0 0", triggered[0], any_trip); end
    checks++; if (cnt_of(count_o, 0) !== 4'd0 || warning[0] !== 1'b0) begin errors++; $display("FAIL disable_count got cnt %0d warn %b exp 0 0", cnt_of(count_o, 0), warning[0]); end
    checks++; if (sys_reset_o !== 1'b1) begin errors++; $display("FAIL disable_pulse_kept got %b exp 1", sys_reset_o); end
  endtask

  task automatic test_reset_mid_pulse;
    do_reset;
    enable = 4'b0001;
    tick;
    heartbeat = 4'b0001; tick;
    heartbeat = '0;
    force_reset = 1'b1; tick;
    force_reset = 1'b0; tick;
    checks++; if (sys_reset_o !== 1'b1 || cnt_of(count_o, 0) !== 4'd2) begin errors++; $display("FAIL midpulse_pre got rst %b cnt %0d exp 1 2", sys_reset_o, cnt_of(count_o, 0)); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (sys_reset_o !== 1'b0 || count_o !== 16'h0 || triggered !== 4'b0 || warning !== 4'b0) begin errors++; $display("FAIL midpulse_reset got rst %b cnt %h trig %b warn %b exp all 0", sys_reset_o, count_o, triggered, warning); end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (cnt_of(count_o, 0) !== 4'(k) || sys_reset_o !== 1'b0) begin errors++; $display("FAIL midpulse_restart step %0d got cnt %0d rst %b exp %0d 0", k, cnt_of(count_o, 0), sys_reset_o, k); end
    end
  endtask

  initial begin
    rst = 1'b1; enable = '0; heartbeat = '0; clear = '0; force_reset = 1'b0;
    test_reset;
    test_basic_timeout;
    test_keepalive;
    test_boundary_race;
    test_multi_sticky;
    test_force_disable;
    test_reset_mid_pulse;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_channel_watchdog.md
Name: multi_channel_watchdog

Overview:
Parametrised N-channel successor to the single-channel watchdog timer. Each channel supervises one heartbeat source with its own counter, a warning threshold and a timeout. The block aggregates channel faults into a fault index and a fixed-length system reset pulse. It sits between the per-subsystem heartbeat generators and the top-level reset sequencer.

Parameters:
N_CH, 4, number of supervised channels (1..16)
WARN_CYCLES, 6, counter value at and above which a channel's warning asserts
TIMEOUT_CYCLES, 10, counter value at which a channel trips; must satisfy 0 < WARN_CYCLES < TIMEOUT_CYCLES
RESET_PULSE, 3, sys_reset_o pulse length in cycles (>=1)
STICKY, 1, 1 = trip cleared only by clear[i] or rst; 0 = heartbeat also clears a trip
CNT_W, $clog2(TIMEOUT_CYCLES+1), derived counter width

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
heartbeat  in  N_CH  per-channel heartbeat; 1-cycle or level, sampled each edge
enable  in  N_CH  per-channel enable
clear  in  N_CH  per-channel trip clear (1-cycle pulse)
force_reset  in  1  software request for a system reset pulse
warning  out  N_CH  channel counter >= WARN_CYCLES and not tripped
triggered  out  N_CH  channel tripped
any_trip  out  1  OR of triggered
fault_id  out  4  lowest index with triggered set; 0 when any_trip=0
sys_reset_o  out  1  system reset pulse
count_o  out  N_CH*CNT_W  packed per-channel counters; channel i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset (rst=1 at an edge): all channels go to IDLE, counters 0; warning, triggered, any_trip, fault_id, sys_reset_o all 0; pulse counter 0. Reset overrides every other input, including mid-pulse and mid-trip.
- Per-channel FSM, states IDLE, RUN, TRIP. Priority order: rst, then enable=0, then clear, then heartbeat, then count.
- IDLE: counter held at 0, all flags 0. enable=1 -> RUN with counter 0.
- Any state with enable[i]=0: -> IDLE next edge, counter 0, trip dropped. Disable wins over a simultaneous heartbeat or timeout.
- RUN, heartbeat=1: counter <- 0.
- RUN, heartbeat=0: counter <- counter+1. On the edge where counter == TIMEOUT_CYCLES-1, the channel goes to TRIP with counter = TIMEOUT_CYCLES. So triggered is high TIMEOUT_CYCLES edges after the last heartbeat edge.
- A heartbeat on the same edge as the would-be timeout wins: counter 0, no trip.
- warning[i] = (state==RUN && counter >= WARN_CYCLES). It is a registered-state decode, so it has no extra latency.
- TRIP: counter saturates at TIMEOUT_CYCLES. clear[i]=1 -> RUN, counter 0. If STICKY=0, heartbeat[i]=1 also -> RUN, counter 0. If STICKY=1, heartbeat is ignored in TRIP. clear in IDLE or RUN has no effect.
- fault_id / any_trip: combinational from the triggered vector, using lowest-index priority.
- Pulse generator:
  - Pulse event = rising edge of any triggered bit (per-channel, registered previous value), or force_reset=1.
  - If the generator is idle, an event at edge t drives sys_reset_o high from edge t+1 for exactly RESET_PULSE cycles.
  - Events while the pulse is active are ignored (no extension, no queueing).
  - Further channels tripping while any_trip is already high still count as events.
- force_reset does not change channel state.
- Counter arithmetic is unsigned, CNT_W bits, and never wraps because of saturation.

Test Plan:
(N_CH=4, WARN=6, TIMEOUT=10, PULSE=3, STICKY=1 unless stated.)
- Basic timeout: after rst, enable=4'b0001, heartbeat[0] high at edge 0 then low:
  - count 6 after edge 6 -> warning[0]=1.
  - triggered[0]=1 after edge 10; warning[0]=0.
  - sys_reset_o=1 after edges 11,12,13, and 0 after edge 14.
- Heartbeat keep-alive: heartbeat[0] every 9 cycles for 100 cycles -> triggered stays 0; warning[0] pulses high for counts 6..8.
- Boundary race: heartbeat[0] exactly on the edge where count=9 -> count 0, no trip, no sys_reset_o.
- Multi-channel and sticky:
  - Channels 2 and 1 trip 2 cycles apart -> fault_id=2, then 1.
  - The second trip falls inside the first pulse -> a single 3-cycle pulse.
  - heartbeat[1] has no effect; clear[1] -> fault_id=2.
  - With STICKY=0, heartbeat[2] clears its trip.
- force_reset and disable:
  - force_reset pulse -> sys_reset_o 3 cycles, channel counters unaffected.
  - enable[0]=0 while tripped -> IDLE, triggered[0]=0, count 0.
- Reset mid-pulse: rst during the second pulse cycle -> all outputs 0 next edge; after rst release with enable held, counters restart from 0.
